p1_mem_read: RTL and testbench
==============================

Name: p1_mem_read

Overview:
- Read-side address generator for the pooling-1 output memory: 12x12 feature map, 144 words, row-major, address = row*12 + col.
- Walks every 5x5 window at stride 1 (8x8 = 64 window positions, 25 reads each, 1600 reads total).
- Tags the returned memory data with valid/first/last and the window position, so the conv-2 MAC can consume it.
- Counterpart of the pooling-1 write counter. Starts once that writer reports done.

Parameters:
- MAP_W, 12, feature-map side length
- K, 5, kernel side length
- ADDR_W, 8, memory address width
- RD_LAT, 1, memory read latency in cycles (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a full map sweep; accepted in IDLE or DONE only
- ready  in  1  downstream can accept a read issued this cycle
- rd_en  out  1  memory read enable
- addr  out  ADDR_W  memory read address
- valid  out  1  memory data valid this cycle
- first  out  1  with valid: element (kr=0,kc=0) of a window
- last  out  1  with valid: element (kr=K-1,kc=K-1) of a window
- out_row  out  3  with valid: window row index 0..7
- out_col  out  3  with valid: window column index 0..7
- busy  out  1  state is RUN or DRAIN
- done  out  1  sweep complete; held until next start

Behaviour:
- One clock, clk. reset is asynchronous, active-low.
- While reset is low:
  - state = IDLE
  - counters orow, ocol, kr, kc = 0
  - RD_LAT pipeline cleared
  - all outputs 0
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN with counters zeroed.
- RUN, issue rules:
  - rd_en = ready (combinational).
  - addr = (orow+kr)*MAP_W + (ocol+kc), computed combinationally from registered counters.
  - addr is 0 when rd_en=0.
- RUN, counter advance (only on cycles with rd_en=1):
  - kc increments.
  - kc wraps at K-1 -> kc=0, kr increments.
  - kr wraps at K-1 -> kr=0, ocol increments.
  - ocol wraps at MAP_W-K -> ocol=0, orow increments.
- Final issue (orow=ocol=7, kr=kc=4, addr=143) -> DRAIN.
- ready=0 in RUN: no issue, counters hold, no timeout.
- DRAIN: stays RD_LAT cycles, then -> DONE.
- DONE: done=1.
  - start=1 -> RUN with counters zeroed, done deasserted the next cycle.
- start in RUN or DRAIN is ignored.
- Output pipeline: valid, first, last, out_row, out_col are rd_en and tags delayed exactly RD_LAT cycles, registered.
  - Downstream must accept every valid; ready only throttles new issues.
- Timing with ready held high, start sampled at edge E0:
  - rd_en high for cycles 1..1600 after E0.
  - valid high for cycles 1+RD_LAT..1600+RD_LAT.
  - done rises the cycle after the final valid.
- Address arithmetic uses ADDR_W bits. Maximum 143, no overflow.
- busy = (state==RUN || state==DRAIN).
- Reset mid-sweep: immediate return to IDLE. In-flight valids are discarded, no partial done.

Decomposition:
- Package p1_mem_pkg:
  - MAP_W, K, OUT_W = MAP_W-K+1, ADDR_W, TOTAL_READS = OUT_W*OUT_W*K*K
  - typedef enum for the state (IDLE/RUN/DRAIN/DONE)
- Sub-module p1_read_pipe: RD_LAT-deep register delay line carrying {valid, first, last, out_row, out_col}, asynchronous active-low reset.
- Counter/FSM logic stays in p1_mem_read.

Test Plan:
- Reset low then high, no start -> all outputs 0, busy=0, done=0 indefinitely.
- start pulse, ready=1 -> first window addrs 0,1,2,3,4,12,13,...,52. first with addr 0 data, last with addr 52 data. out_row=0, out_col=0.
- Full sweep, ready=1 -> exactly 1600 valids, 64 first and 64 last. Final window (7,7) addrs 91..143. done rises one cycle after final valid.
- ready toggled 1,0,1,0 -> counters hold on ready=0. Address sequence identical to the ready=1 run, only stretched. No valid the cycle after a ready=0 cycle.
- reset asserted at read 700 -> next cycle valid=0 and busy=0. A new start restarts at addr 0 and completes 1600 reads.
- start asserted in RUN -> ignored, sequence unaffected. start in DONE -> done drops next cycle, second full sweep matches the first.

Source files
------------

// File: rtl/p1_mem_pkg.sv
// p1_mem_pkg: shared constants, state encoding, tag payload and address helper
// for the pooling-1 output memory read generator.
//   MAP_W       feature-map side length (words per row)
//   K           conv-2 kernel side length
//   OUT_W       window positions per axis (MAP_W-K+1)
//   ADDR_W      memory address width
//   TOTAL_READS reads in one full map sweep
package p1_mem_pkg;

    localparam int unsigned MAP_W       = 12;
    localparam int unsigned K           = 5;
    localparam int unsigned OUT_W       = MAP_W - K + 1;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned TOTAL_READS = OUT_W * OUT_W * K * K;

    // Window index width (0..OUT_W-1) and kernel index width (0..K-1)
    localparam int unsigned IDX_W = 3;
    localparam int unsigned KC_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Sideband that travels alongside a read until its data returns
    typedef struct packed {
        logic             valid;
        logic             first;
        logic             last;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } rd_tag_t;

    // Row-major word address of kernel element (kr,kc) in window (orow,ocol)
    function automatic logic [ADDR_W-1:0] win_addr(
        input logic [IDX_W-1:0] orow,
        input logic [IDX_W-1:0] ocol,
        input logic [KC_W-1:0]  kr,
        input logic [KC_W-1:0]  kc
    );
        logic [ADDR_W-1:0] row_sum;
        logic [ADDR_W-1:0] col_sum;
        row_sum  = ADDR_W'(orow) + ADDR_W'(kr);
        col_sum  = ADDR_W'(ocol) + ADDR_W'(kc);
        win_addr = ADDR_W'(row_sum * ADDR_W'(MAP_W)) + col_sum;
    endfunction

endpackage

// File: rtl/p1_read_pipe.sv
// p1_read_pipe: DEPTH-stage register delay line that lines the read tag up
// with data returning from a memory of DEPTH-cycle read latency.
//   clk    system clock
//   reset  asynchronous active-low reset, clears every stage
//   din    tag of the read issued this cycle
//   dout   tag of the read issued DEPTH cycles ago
module p1_read_pipe
    import p1_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t din,
    output rd_tag_t dout
);

    rd_tag_t stage [DEPTH];

    // Shift register; reset drops every in-flight tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/p1_mem_read.sv
// p1_mem_read: read-side address generator for the pooling-1 output memory.
// Sweeps every KxK window of the MAP_W x MAP_W map at stride 1 and tags the
// returning data with valid/first/last and the window position for conv-2.
//   clk      system clock
//   reset    asynchronous active-low reset
//   start    begin a full sweep (honoured in IDLE or DONE only)
//   ready    downstream can take a read issued this cycle
//   rd_en    memory read enable (combinational, = ready while running)
//   addr     memory read address, 0 when rd_en is low
//   valid    memory data valid (rd_en delayed RD_LAT cycles)
//   first    with valid: kernel element (0,0) of a window
//   last     with valid: kernel element (K-1,K-1) of a window
//   out_row  with valid: window row 0..OUT_W-1
//   out_col  with valid: window column 0..OUT_W-1
//   busy     sweep in progress (RUN or DRAIN)
//   done     sweep complete, held until the next start
module p1_mem_read
    import p1_mem_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              first,
    output logic              last,
    output logic [IDX_W-1:0]  out_row,
    output logic [IDX_W-1:0]  out_col,
    output logic              busy,
    output logic              done
);

    localparam int unsigned DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t               state;
    logic [IDX_W-1:0]     orow;
    logic [IDX_W-1:0]     ocol;
    logic [KC_W-1:0]      kr;
    logic [KC_W-1:0]      kc;
    logic [DRAIN_W-1:0]   drain_cnt;

    logic                 kc_end;
    logic                 kr_end;
    logic                 ocol_end;
    logic                 orow_end;
    logic                 final_issue;
    rd_tag_t              issue_tag;
    rd_tag_t              out_tag;

    // Issue side: read enable, address and tag from the registered counters
    always_comb begin
        kc_end      = (kc == KC_W'(K - 1));
        kr_end      = (kr == KC_W'(K - 1));
        ocol_end    = (ocol == IDX_W'(OUT_W - 1));
        orow_end    = (orow == IDX_W'(OUT_W - 1));

        rd_en       = (state == ST_RUN) && ready;
        addr        = rd_en ? win_addr(orow, ocol, kr, kc) : '0;
        final_issue = rd_en && kc_end && kr_end && ocol_end && orow_end;

        issue_tag       = '0;
        issue_tag.valid = rd_en;
        issue_tag.first = rd_en && (kr == '0) && (kc == '0);
        issue_tag.last  = rd_en && kr_end && kc_end;
        issue_tag.row   = rd_en ? orow : '0;
        issue_tag.col   = rd_en ? ocol : '0;
    end

    // Sweep FSM and nested window/kernel counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            orow      <= '0;
            ocol      <= '0;
            kr        <= '0;
            kc        <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        orow      <= '0;
                        ocol      <= '0;
                        kr        <= '0;
                        kc        <= '0;
                        drain_cnt <= '0;
                    end
                end

                ST_RUN: begin
                    // Counters only move on cycles that actually issue a read
                    if (rd_en) begin
                        if (final_issue) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end
                        if (!kc_end) begin
                            kc <= kc + KC_W'(1);
                        end else begin
                            kc <= '0;
                            if (!kr_end) begin
                                kr <= kr + KC_W'(1);
                            end else begin
                                kr <= '0;
                                if (!ocol_end) begin
                                    ocol <= ocol + IDX_W'(1);
                                end else begin
                                    ocol <= '0;
                                    orow <= orow_end ? '0 : orow + IDX_W'(1);
                                end
                            end
                        end
                    end
                end

                ST_DRAIN: begin
                    // Wait out the read latency so the final valid leaves first
                    if (drain_cnt == DRAIN_W'(RD_LAT - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

    p1_read_pipe #(
        .DEPTH (RD_LAT)
    ) u_pipe (
        .clk   (clk),
        .reset (reset),
        .din   (issue_tag),
        .dout  (out_tag)
    );

    assign valid   = out_tag.valid;
    assign first   = out_tag.first;
    assign last    = out_tag.last;
    assign out_row = out_tag.row;
    assign out_col = out_tag.col;

endmodule

// File: tb/tb_p1_mem_read.sv
// tb_p1_mem_read: scoreboard bench for p1_mem_read. Each start pushes the
// expected read sequence; a monitor pops and compares on every valid.
module tb_p1_mem_read;
    import p1_mem_pkg::*;

    localparam int unsigned RD_LAT = 1;

    logic              clk;
    logic              reset;
    logic              start;
    logic              ready;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              first;
    logic              last;
    logic [IDX_W-1:0]  out_row;
    logic [IDX_W-1:0]  out_col;
    logic              busy;
    logic              done;

    p1_mem_read #(
        .RD_LAT (RD_LAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .ready   (ready),
        .rd_en   (rd_en),
        .addr    (addr),
        .valid   (valid),
        .first   (first),
        .last    (last),
        .out_row (out_row),
        .out_col (out_col),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int row;
        int col;
        bit first;
        bit last;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int e0    = 0;
    int issue_cnt, valid_cnt, first_cnt, last_cnt;
    int first_valid_cyc, last_valid_cyc, done_rise_cyc;
    int cap_head [25];
    int cap_tail [25];
    int prev_issue_addr = 0;
    bit prev_rd_en = 0;
    bit prev_done  = 0;

    // Hand-derived address lists of window (0,0) and window (7,7)
    int win0_ref [25] = '{0, 1, 2, 3, 4, 12, 13, 14, 15, 16, 24, 25, 26, 27, 28,
                          36, 37, 38, 39, 40, 48, 49, 50, 51, 52};
    int winl_ref [25] = '{91, 92, 93, 94, 95, 103, 104, 105, 106, 107,
                          115, 116, 117, 118, 119, 127, 128, 129, 130, 131,
                          139, 140, 141, 142, 143};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: data model is mem[a] = a returning one cycle after issue
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset) begin
            if (rd_en) begin
                issue_cnt++;
                if (!ready) check("rd_en_without_ready", ready, 1);
            end else if (addr != 0) begin
                check("addr_zero_when_idle", addr, 0);
            end
            if (valid) begin
                check("valid_follows_issue", prev_rd_en, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_addr", prev_issue_addr, e.addr);
                    check("out_row", out_row, e.row);
                    check("out_col", out_col, e.col);
                    check("first", first, e.first);
                    check("last", last, e.last);
                    if (valid_cnt < 25) cap_head[valid_cnt] = prev_issue_addr;
                    cap_tail[valid_cnt % 25] = prev_issue_addr;
                    if (valid_cnt == 0) first_valid_cyc = cyc;
                    last_valid_cyc = cyc;
                    valid_cnt++;
                    if (first) first_cnt++;
                    if (last) last_cnt++;
                end
            end
            if (done && !prev_done) done_rise_cyc = cyc;
        end
        prev_rd_en      = rd_en && reset;
        prev_issue_addr = addr;
        prev_done       = done;
    end

    task automatic push_sweep();
        exp_t e;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                for (int kr = 0; kr < 5; kr++)
                    for (int kc = 0; kc < 5; kc++) begin
                        e.addr  = (r + kr) * 12 + (c + kc);
                        e.row   = r;
                        e.col   = c;
                        e.first = (kr == 0) && (kc == 0);
                        e.last  = (kr == 4) && (kc == 4);
                        exp_q.push_back(e);
                    end
    endtask

    task automatic do_start();
        push_sweep();
        issue_cnt = 0; valid_cnt = 0; first_cnt = 0; last_cnt = 0;
        first_valid_cyc = -1; last_valid_cyc = -1; done_rise_cyc = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        e0 = cyc;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
    endtask

    task automatic wait_done(input bit toggle, input bit pulse_run);
        bit pulsed = 0;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            if (toggle) ready = ~ready;
            start = 1'b0;
            if (pulse_run && !pulsed && issue_cnt >= 300) begin
                start  = 1'b1;
                pulsed = 1;
            end
            @(negedge clk);
            if (done) break;
        end
        start = 1'b0;
        ready = 1'b1;
        check("done_timeout", done, 1);
    endtask

    task automatic check_sweep(input bit exact_timing);
        check("issue_count", issue_cnt, TOTAL_READS);
        check("valid_count", valid_cnt, 1600);
        check("first_count", first_cnt, 64);
        check("last_count", last_cnt, 64);
        check("scoreboard_empty", exp_q.size(), 0);
        for (int i = 0; i < 25; i++) check("win0_addr", cap_head[i], win0_ref[i]);
        for (int i = 0; i < 25; i++) check("win77_addr", cap_tail[i], winl_ref[i]);
        check("done_after_last_valid", done_rise_cyc, last_valid_cyc + 1);
        if (exact_timing) begin
            check("first_valid_cycle", first_valid_cyc, e0 + RD_LAT);
            check("last_valid_cycle", last_valid_cyc, e0 + 1599 + RD_LAT);
        end
        repeat (5) @(negedge clk);
        check("done_held", {busy, done}, 2'b01);
    endtask

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {rd_en, valid, first, last, busy, done, addr, out_row, out_col}, 0);
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {rd_en, valid, first, last, busy, done, addr, out_row, out_col}, 0);
        end

        // Full sweep, ready held high
        do_start();
        wait_done(0, 0);
        check_sweep(1);

        // ready toggling: same sequence, stretched
        do_start();
        wait_done(1, 0);
        check_sweep(0);

        // start mid-run is ignored
        do_start();
        wait_done(0, 1);
        check_sweep(1);

        // start from DONE: done drops, second sweep matches
        check("done_before_restart", done, 1);
        do_start();
        wait_done(0, 0);
        check_sweep(1);

        // Reset in the middle of a sweep
        do_start();
        for (int i = 0; i < 3000 && issue_cnt < 700; i++) @(negedge clk);
        check("reached_read_700", issue_cnt >= 700, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("reset_mid_outputs", {rd_en, valid, busy, done}, 0);
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {rd_en, valid, busy, done}, 0);
        do_start();
        wait_done(0, 0);
        check_sweep(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
